// File: rtl/mixer_nch_if.sv
// Bus bundle for mixer_nch: sample tick, channel inputs and the scaled mix result.
// The master side is the generator/control logic, the slave side is the mixer.
interface mixer_nch_if #(
  parameter int NUM_CH = 4,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 8
);
  logic                    sample_tick;
  logic [NUM_CH-1:0]       wave;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*VOL_W-1:0] volume;
  logic [OUT_W-1:0]        mixout;
  logic                    mix_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    output sample_tick, wave, enable, volume,
    input  mixout, mix_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, wave, enable, volume,
    output mixout, mix_valid, busy, overrun
  );
endinterface

// File: rtl/mixer_nch.sv
// Time-multiplexed NUM_CH-channel sound mixer: one channel summed per clock per sample tick.
// Define MIXER_SLEW_EN to step per-channel volumes by one toward their targets on every tick.
module mixer_nch #(
  parameter int NUM_CH = 4,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 8
) (
  input logic         clk,
  input logic         rst_n,
  mixer_nch_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SUM_W = VOL_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   addend;
  logic [OUT_W-1:0]   mixout;
  logic [OUT_W-1:0]   scaled;
  logic               mix_valid;
  logic               overrun;
  logic               accept;
  logic               load_out;
  logic               tick_busy;
  logic               last;

  logic [NUM_CH-1:0]  snap_wave;
  logic [NUM_CH-1:0]  snap_en;
  logic [VOL_W-1:0]   snap_vol [NUM_CH];
  logic [VOL_W-1:0]   tgt_vol  [NUM_CH];
  logic [VOL_W-1:0]   eff_vol  [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_vol[i] = bus.volume[i*VOL_W +: VOL_W];
    end
  end

`ifdef MIXER_SLEW_EN
  logic [VOL_W-1:0] cur_vol [NUM_CH];

  // The stepped value, not the old register, is what the pass uses.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (tgt_vol[i] > cur_vol[i]) begin
        eff_vol[i] = cur_vol[i] + 1'b1;
      end else if (tgt_vol[i] < cur_vol[i]) begin
        eff_vol[i] = cur_vol[i] - 1'b1;
      end else begin
        eff_vol[i] = cur_vol[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_vol <= '{default: '0};
    end else if (accept) begin
      cur_vol <= eff_vol;
    end
  end
`else
  always_comb begin
    eff_vol = tgt_vol;
  end
`endif

  assign last   = (idx == IDX_W'(NUM_CH - 1));
  assign addend = (snap_en[idx] & snap_wave[idx]) ? SUM_W'(snap_vol[idx]) : '0;

  generate
    if (SUM_W <= OUT_W) begin : g_scale_up
      assign scaled = OUT_W'(acc) << (OUT_W - SUM_W);
    end else begin : g_scale_down
      assign scaled = OUT_W'(acc >> (SUM_W - OUT_W));
    end
  endgenerate

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load_out   = 1'b0;
    tick_busy  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.sample_tick) begin
          accept     = 1'b1;
          state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        tick_busy = bus.sample_tick;
        if (last) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        tick_busy  = bus.sample_tick;
        load_out   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      mixout    <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      mix_valid <= load_out;
      if (tick_busy) begin
        overrun <= 1'b1;
      end
      if (accept) begin
        acc <= '0;
        idx <= '0;
      end else if (state == S_ACCUM) begin
        acc <= acc + addend;
        idx <= idx + 1'b1;
      end
      if (load_out) begin
        mixout <= scaled;
      end
    end
  end

  // NOTE: snapshot registers carry no reset; they are always loaded on the tick before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      snap_wave <= bus.wave;
      snap_en   <= bus.enable;
      snap_vol  <= eff_vol;
    end
  end

  assign bus.mixout    = mixout;
  assign bus.mix_valid = mix_valid;
  assign bus.busy      = (state != S_IDLE);
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_mixer_nch.sv
// Self-checking bench for mixer_nch: directed timing/gating/overrun/reset cases plus random
// passes against a sum-and-scale reference model, on 4-, 8- and 2-channel instances.
module tb_mixer_nch;

`ifdef MIXER_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mixer_nch_if #(.NUM_CH(4), .VOL_W(4), .OUT_W(8)) a ();
  mixer_nch_if #(.NUM_CH(8), .VOL_W(4), .OUT_W(8)) b ();
  mixer_nch_if #(.NUM_CH(2), .VOL_W(4), .OUT_W(4)) c ();

  mixer_nch #(.NUM_CH(4), .VOL_W(4), .OUT_W(8)) dut   (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  mixer_nch #(.NUM_CH(8), .VOL_W(4), .OUT_W(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  mixer_nch #(.NUM_CH(2), .VOL_W(4), .OUT_W(4)) dut2  (.clk(clk), .rst_n(rst_n), .bus(c.slave));

  int n_vec = 0;
  int n_err = 0;
  int cur4 [4];
  int cur8 [8];
  int cur2 [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Effective volume for the next accepted tick.
  function automatic int slew_step(input int cur, input int tgt);
    if (!SLEW) return tgt;
    if (tgt > cur) return cur + 1;
    if (tgt < cur) return cur - 1;
    return cur;
  endfunction

  function automatic int scale(input int sum, input int nch, input int vol_w, input int out_w);
    int sum_w;
    sum_w = vol_w + $clog2(nch);
    if (sum_w <= out_w) return sum * (2 ** (out_w - sum_w));
    return sum / (2 ** (sum_w - out_w));
  endfunction

  task automatic predict4(input logic [3:0] w, input logic [3:0] e, input logic [15:0] v,
                          output int exp);
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      cur4[i] = slew_step(cur4[i], int'(v[i*4 +: 4]));
      if (w[i] && e[i]) sum += cur4[i];
    end
    exp = scale(sum, 4, 4, 8);
  endtask

  // Ticks in the current cycle T and ends in cycle T+6 (the mix_valid cycle).
  task automatic do_pass4(input logic [3:0] w, input logic [3:0] e, input logic [15:0] v,
                          input string tag, input int flip_at, input int tick_at);
    int exp;
    predict4(w, e, v, exp);
    a.wave = w;
    a.enable = e;
    a.volume = v;
    a.sample_tick = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      a.sample_tick = (k == tick_at);
      if (k == flip_at) a.wave = ~w;
      check($sformatf("%s_busy_T%0d", tag, k), 32'(a.busy), 32'd1);
      check($sformatf("%s_nvalid_T%0d", tag, k), 32'(a.mix_valid), 32'd0);
      step();
    end
    a.sample_tick = 1'b0;
    check({tag, "_valid"}, 32'(a.mix_valid), 32'd1);
    check({tag, "_idle"}, 32'(a.busy), 32'd0);
    check({tag, "_mixout"}, 32'(a.mixout), 32'(exp));
  endtask

  initial begin
    logic [3:0]  rw;
    logic [3:0]  re;
    logic [15:0] rv;
    int          exp;
    int          sum;

    foreach (cur4[i]) cur4[i] = 0;
    foreach (cur8[i]) cur8[i] = 0;
    foreach (cur2[i]) cur2[i] = 0;
    a.sample_tick = 1'b0; a.wave = '0; a.enable = '0; a.volume = '0;
    b.sample_tick = 1'b0; b.wave = '0; b.enable = '0; b.volume = '0;
    c.sample_tick = 1'b0; c.wave = '0; c.enable = '0; c.volume = '0;

    repeat (3) step();
    check("rst_mixout", 32'(a.mixout), 32'd0);
    check("rst_valid", 32'(a.mix_valid), 32'd0);
    check("rst_busy", 32'(a.busy), 32'd0);
    check("rst_overrun", 32'(a.overrun), 32'd0);
    check("rst_mixout8", 32'(b.mixout), 32'd0);
    check("rst_mixout2", 32'(c.mixout), 32'd0);
    rst_n = 1'b1;
    step();

    do_pass4(4'hF, 4'hF, 16'hFFFF, "full", 0, 0);
    step();
    check("full_pulse_len", 32'(a.mix_valid), 32'd0);
    check("full_hold", 32'(a.mixout), 32'(scale(SLEW ? 4 : 60, 4, 4, 8)));

    do_pass4(4'b1101, 4'b1011, 16'h2F35, "gate", 2, 0);
    step();
    check("no_overrun_yet", 32'(a.overrun), 32'd0);

    rw = 4'($urandom()); re = 4'($urandom()); rv = 16'($urandom());
    do_pass4(rw, re, rv, "ovr1", 0, 3);
    check("ovr_set", 32'(a.overrun), 32'd1);
    rw = 4'($urandom()); re = 4'($urandom()); rv = 16'($urandom());
    do_pass4(rw, re, rv, "ovr2_back2back", 0, 0);
    check("ovr_sticky", 32'(a.overrun), 32'd1);

    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 2)) step();
      rw = 4'($urandom()); re = 4'($urandom()); rv = 16'($urandom());
      do_pass4(rw, re, rv, $sformatf("rnd%0d", n), 0, 0);
    end

    step();
    do_pass4(4'hF, 4'hF, 16'hFFFF, "prerst", 0, 0);
    a.sample_tick = 1'b1;
    step();
    a.sample_tick = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    step();
    check("midrst_mixout", 32'(a.mixout), 32'd0);
    check("midrst_valid", 32'(a.mix_valid), 32'd0);
    check("midrst_busy", 32'(a.busy), 32'd0);
    check("midrst_overrun", 32'(a.overrun), 32'd0);
    foreach (cur4[i]) cur4[i] = 0;
    foreach (cur8[i]) cur8[i] = 0;
    foreach (cur2[i]) cur2[i] = 0;
    rst_n = 1'b1;
    step();
    do_pass4(4'b0111, 4'b1111, 16'h9A7C, "postrst", 0, 0);
    step();

    for (int p = 0; p < 2; p++) begin
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        cur8[i] = slew_step(cur8[i], 15);
        sum += cur8[i];
      end
      exp = scale(sum, 8, 4, 8);
      b.wave = '1; b.enable = '1; b.volume = '1; b.sample_tick = 1'b1;
      step();
      b.sample_tick = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        check($sformatf("ch8_p%0d_nvalid_T%0d", p, k), 32'(b.mix_valid), 32'd0);
        step();
      end
      check($sformatf("ch8_p%0d_valid", p), 32'(b.mix_valid), 32'd1);
      check($sformatf("ch8_p%0d_mixout", p), 32'(b.mixout), 32'(exp));
      step();
    end

    for (int p = 0; p < 2; p++) begin
      sum = 0;
      for (int i = 0; i < 2; i++) begin
        cur2[i] = slew_step(cur2[i], 15);
        sum += cur2[i];
      end
      exp = scale(sum, 2, 4, 4);
      c.wave = '1; c.enable = '1; c.volume = '1; c.sample_tick = 1'b1;
      step();
      c.sample_tick = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        check($sformatf("ch2_p%0d_busy_T%0d", p, k), 32'(c.busy), 32'd1);
        step();
      end
      check($sformatf("ch2_p%0d_valid", p), 32'(c.mix_valid), 32'd1);
      check($sformatf("ch2_p%0d_mixout", p), 32'(c.mixout), 32'(exp));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
